mem_stream_sched: RTL

//  Read scheduler for the 24:1 registered memory-readout mux. Per event (BX), latches per-memory entry counts.

---
 rtl/mem_stream_sched_pkg.sv | 8 +
 rtl/mem_stream_sched_if.sv | 26 ++
 rtl/mem_stream_sched_find_next.sv | 21 ++
 rtl/mem_stream_sched.sv | 114 +++++++++++
 4 files changed

// File: rtl/mem_stream_sched_pkg.sv
// mem_sched_pkg: shared sizes and FSM state type for the readout scheduler
package mem_sched_pkg;
  localparam int NMEM = 24;
  localparam int SEL_W = 5;
  localparam int NENT_W = 6;
  localparam int BX_W = 3;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;
endpackage

// File: rtl/mem_stream_sched_if.sv
// mem_stream_sched_if: event inputs plus read-side and stream-side outputs of the scheduler
interface mem_stream_sched_if;
  import mem_sched_pkg::*;
  logic start;
  logic [BX_W-1:0] bx_in;
  logic [NMEM*NENT_W-1:0] nent_flat;
  logic [NMEM-1:0] en_mask;
  logic rd_en;
  logic [BX_W+NENT_W-1:0] rd_addr;
  logic [SEL_W-1:0] rd_mem;
  logic [SEL_W-1:0] sel;
  logic out_valid;
  logic out_last;
  logic [BX_W-1:0] out_bx;
  logic busy;
  logic done;
  logic truncated;
  modport master (
    input start, bx_in, nent_flat, en_mask,
    output rd_en, rd_addr, rd_mem, sel, out_valid, out_last, out_bx, busy, done, truncated
  );
  modport slave (
    output start, bx_in, nent_flat, en_mask,
    input rd_en, rd_addr, rd_mem, sel, out_valid, out_last, out_bx, busy, done, truncated
  );
endinterface

// File: rtl/mem_stream_sched_find_next.sv
// mem_sched_find_next: lowest candidate memory above cur (or anywhere when first is set)
module mem_sched_find_next
  import mem_sched_pkg::*;
(
  input  logic [NMEM-1:0]  cand,
  input  logic [SEL_W-1:0] cur,
  input  logic             first,
  output logic             found,
  output logic [SEL_W-1:0] idx
);
  // scan downwards so the lowest qualifying index is the one that sticks
  always_comb begin
    found = 1'b0;
    idx = '0;
    for (int i = NMEM - 1; i >= 0; i--)
      if (cand[i] && (first || i > int'(cur))) begin
        found = 1'b1;
        idx = SEL_W'(i);
      end
  end
endmodule

// File: rtl/mem_stream_sched.sv
// mem_stream_sched: per-BX read walk over enabled memories with latency-aligned mux select and stream tags
module mem_stream_sched
  import mem_sched_pkg::*;
#(
  parameter int MEM_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  mem_stream_sched_if.master s
);
  localparam int D = MEM_LAT + 2;
  state_t state, state_nx;
  logic [BX_W-1:0] bx_q;
  logic [NMEM*NENT_W-1:0] cnt_q;
  logic [NMEM-1:0] mask_q, nz_q, nz_in;
  logic [SEL_W-1:0] cur, nidx, sidx;
  logic [NENT_W-1:0] ent;
  logic nf, sf, last_ent, final_issue, empty_q, drained;
  logic [D-1:0] mk;
  logic [MEM_LAT:0] pv, pl;
  logic [SEL_W-1:0] pm [MEM_LAT];
  logic [BX_W-1:0] pb [MEM_LAT+1];

  // non-empty flags for the latched event and for the event being offered on start
  always_comb begin
    nz_q = '0;
    nz_in = '0;
    for (int i = 0; i < NMEM; i++) begin
      nz_q[i] = |cnt_q[i*NENT_W +: NENT_W];
      nz_in[i] = |s.nent_flat[i*NENT_W +: NENT_W];
    end
  end

  mem_sched_find_next u_next (
    .cand(mask_q & nz_q), .cur(cur), .first(1'b0), .found(nf), .idx(nidx)
  );

  mem_sched_find_next u_first (
    .cand(s.en_mask & nz_in), .cur('0), .first(1'b1), .found(sf), .idx(sidx)
  );

  assign last_ent = ent + NENT_W'(1) == cnt_q[cur*NENT_W +: NENT_W];

  // a start is accepted in every state; otherwise walk, then wait for the final done marker
  always_comb begin
    final_issue = state == ISSUE && last_ent && !nf;
    drained = mk[D-1] && mk[D-2:0] == '0 && !empty_q;
    state_nx = s.start ? (sf ? ISSUE : DRAIN) :
               state == ISSUE ? (final_issue ? DRAIN : ISSUE) :
               state == DRAIN ? (drained ? IDLE : DRAIN) : IDLE;
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;

  // event latch and the memory/entry walk
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bx_q <= '0;
      cnt_q <= '0;
      mask_q <= '0;
      cur <= '0;
      ent <= '0;
      empty_q <= 1'b0;
    end else begin
      empty_q <= s.start && !sf;
      if (s.start) begin
        bx_q <= s.bx_in;
        cnt_q <= s.nent_flat;
        mask_q <= s.en_mask;
        cur <= sidx;
        ent <= '0;
      end else if (state == ISSUE) begin
        if (!last_ent) ent <= ent + NENT_W'(1);
        else if (nf) begin
          cur <= nidx;
          ent <= '0;
        end
      end
    end
  end

  // read-latency pipes; select stages only advance on valid so sel holds when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mk <= '0;
      pv <= '0;
      pl <= '0;
      for (int k = 0; k < MEM_LAT; k++) pm[k] <= '0;
      for (int k = 0; k <= MEM_LAT; k++) pb[k] <= '0;
    end else begin
      mk <= {mk[D-2:0], final_issue || empty_q};
      pv <= {pv[MEM_LAT-1:0], s.rd_en};
      pl <= {pl[MEM_LAT-1:0], s.rd_en && (final_issue || s.start)};
      pb[0] <= s.rd_en ? bx_q : '0;
      pm[0] <= s.rd_en ? cur : pm[0];
      for (int k = 1; k <= MEM_LAT; k++) pb[k] <= pb[k-1];
      for (int k = 1; k < MEM_LAT; k++) pm[k] <= pv[k-1] ? pm[k-1] : pm[k];
    end
  end

  assign s.rd_en = state == ISSUE;
  assign s.rd_mem = s.rd_en ? cur : '0;
  assign s.rd_addr = s.rd_en ? {bx_q, ent} : '0;
  assign s.sel = pm[MEM_LAT-1];
  assign s.out_valid = pv[MEM_LAT];
  assign s.out_last = pl[MEM_LAT];
  assign s.out_bx = pb[MEM_LAT];
  assign s.busy = state != IDLE;
  assign s.done = mk[D-1];
  assign s.truncated = s.rd_en && s.start && !final_issue;
endmodule
